// File: rtl/ay_bank_pkg.sv
// Shared definitions for the AY bank: panning modes, port decode bits and
// the output width rule for the stereo mixer.
package ay_bank_pkg;

  typedef enum logic [1:0] {
    STEREO_ABC  = 2'd0,
    STEREO_ACB  = 2'd1,
    STEREO_MONO = 2'd2
  } stereo_mode_t;

  localparam int A15 = 15;
  localparam int A14 = 14;
  localparam int A1  = 1;

  // Select bytes carry all-ones above the inverted chip index.
  localparam logic [7:0] SEL_PREFIX = 8'hFF;

  // One chip contributes at most 2*255+255 = 765, which fits in 10 bits.
  function automatic int mix_width(input int chips);
    return 10 + $clog2(chips);
  endfunction

endpackage

// File: rtl/cpu_bus.sv
// CPU I/O bus seen by the peripherals: address, write data and active-high strobes.
interface cpu_bus;
  logic [15:0] a;
  logic [7:0]  d;
  logic        ioreq;
  logic        rd;
  logic        wr;

  modport periph (input a, d, ioreq, rd, wr);
  modport cpu    (output a, d, ioreq, rd, wr);
endinterface

// File: rtl/ay_bank_psg.sv
// Reduced YM2149-compatible PSG with a register file, an address latch and three
// square-wave tone channels at a fixed 4-bit volume each.
module ay_bank_psg (
  input  logic       CLK,
  input  logic       ENA,
  input  logic       RESET_H,
  input  logic [7:0] I_DA,
  output logic [7:0] O_DA,
  input  logic       busctrl_addr,
  input  logic       busctrl_we,
  output logic [7:0] O_AUDIO_A,
  output logic [7:0] O_AUDIO_B,
  output logic [7:0] O_AUDIO_C
);
  logic [7:0]  regs     [16];
  logic [3:0]  addr;
  logic [11:0] tone_cnt [3];
  logic [11:0] per_m1   [3];
  logic [2:0]  tone;
  logic [2:0]  ch_on;

  // Periods 0 and 1 both toggle on every enable.
  always_comb begin
    for (int unsigned i = 0; i < 3; i++) begin
      per_m1[i] = {regs[2*i+1][3:0], regs[2*i]};
      if (per_m1[i] != '0) per_m1[i] = per_m1[i] - 12'd1;
      ch_on[i] = regs[7][i] | tone[i];
    end
  end

  always_ff @(posedge CLK or posedge RESET_H) begin
    if (RESET_H) begin
      addr <= '0;
      tone <= '0;
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
      for (int unsigned i = 0; i < 3; i++) tone_cnt[i] <= '0;
    end else begin
      if (busctrl_addr && I_DA[7:4] == 4'h0) addr <= I_DA[3:0];
      if (busctrl_we) regs[addr] <= I_DA;
      if (ENA) begin
        for (int unsigned i = 0; i < 3; i++) begin
          if (tone_cnt[i] >= per_m1[i]) begin
            tone_cnt[i] <= '0;
            tone[i]     <= ~tone[i];
          end else begin
            tone_cnt[i] <= tone_cnt[i] + 12'd1;
          end
        end
      end
    end
  end

  assign O_DA      = regs[addr];
  assign O_AUDIO_A = ch_on[0] ? {regs[8][3:0],  4'h0} : '0;
  assign O_AUDIO_B = ch_on[1] ? {regs[9][3:0],  4'h0} : '0;
  assign O_AUDIO_C = ch_on[2] ? {regs[10][3:0], 4'h0} : '0;

endmodule

// File: rtl/ay_mixer.sv
// Registered stereo mixer for a bank of PSGs with ABC/ACB/mono panning and per-chip mute.
module ay_mixer
  import ay_bank_pkg::*;
#(
  parameter int CHIPS = 2,
  parameter int OUT_W = mix_width(CHIPS)
) (
  input  logic                 clk28,
  input  logic                 rst_n,
  input  logic [1:0]           stereo_mode,
  input  logic [CHIPS-1:0]     mute,
  input  logic [CHIPS*8-1:0]   ch_a,
  input  logic [CHIPS*8-1:0]   ch_b,
  input  logic [CHIPS*8-1:0]   ch_c,
  output logic [OUT_W-1:0]     snd_l,
  output logic [OUT_W-1:0]     snd_r
);
  logic [OUT_W-1:0] sum_l, sum_r, a, b, c;

  always_comb begin
    sum_l = '0;
    sum_r = '0;
    a     = '0;
    b     = '0;
    c     = '0;
    for (int unsigned i = 0; i < CHIPS; i++) begin
      a = mute[i] ? '0 : OUT_W'(ch_a[i*8 +: 8]);
      b = mute[i] ? '0 : OUT_W'(ch_b[i*8 +: 8]);
      c = mute[i] ? '0 : OUT_W'(ch_c[i*8 +: 8]);
      case (stereo_mode_t'(stereo_mode))
        STEREO_ABC: begin
          sum_l = sum_l + (a << 1) + b;
          sum_r = sum_r + (c << 1) + b;
        end
        STEREO_ACB: begin
          sum_l = sum_l + (a << 1) + c;
          sum_r = sum_r + (b << 1) + c;
        end
        default: begin
          sum_l = sum_l + a + b + c;
          sum_r = sum_r + a + b + c;
        end
      endcase
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      snd_l <= '0;
      snd_r <= '0;
    end else begin
      snd_l <= sum_l;
      snd_r <= sum_r;
    end
  end

endmodule

// File: rtl/ay_bank.sv
// Bank of PSGs behind the Spectrum 128 AY ports with TurboSound-style chip
// selection, AY clock-enable divider, readback and stereo mixing.
module ay_bank
  import ay_bank_pkg::*;
#(
  parameter int CHIPS  = 2,
  parameter int SEL_W  = 3,
  parameter int CK_DIV = 2,
  parameter int OUT_W  = mix_width(CHIPS)
) (
  input  logic             clk28,
  input  logic             rst_n,
  input  logic             ck35,
  input  logic             en,
  cpu_bus.periph           bus,
  output logic [7:0]       d_out,
  output logic             d_out_active,
  input  logic             pause,
  input  logic [1:0]       stereo_mode,
  input  logic [CHIPS-1:0] mute,
  output logic [OUT_W-1:0] snd_l,
  output logic [OUT_W-1:0] snd_r
);
  localparam int DIV_W  = $clog2(CK_DIV + 1);
  localparam int SLOTS  = 2 ** SEL_W;

  logic             addr_port, data_port, sel_wr;
  logic [SEL_W-1:0] sel, idx;
  logic             addr_stb, data_stb, rd_q, ay_ena;
  logic [7:0]       d_q;
  logic [DIV_W-1:0] div_cnt;
  logic             psg_rst;
  logic [7:0]       psg_do [SLOTS];
  logic [CHIPS*8-1:0] ch_a, ch_b, ch_c;
  logic             unused_addr_bits;

  assign unused_addr_bits = ^{bus.a[13:2], bus.a[0]};
  assign psg_rst          = ~rst_n;

  always_comb begin
    addr_port = bus.ioreq & bus.a[A15] &  bus.a[A14] & ~bus.a[A1];
    data_port = bus.ioreq & bus.a[A15] & ~bus.a[A14] & ~bus.a[A1];
    sel_wr    = en & addr_port & bus.wr & (bus.d[7:SEL_W] == SEL_PREFIX[7:SEL_W]);
    idx       = ~bus.d[SEL_W-1:0];
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      sel      <= '0;
      addr_stb <= 1'b0;
      data_stb <= 1'b0;
      rd_q     <= 1'b0;
      d_q      <= '0;
      div_cnt  <= '0;
      ay_ena   <= 1'b0;
    end else begin
      if (sel_wr && int'(idx) < CHIPS) sel <= idx;
      addr_stb <= en & addr_port & bus.wr & ~sel_wr;
      data_stb <= en & data_port & bus.wr;
      rd_q     <= en & addr_port & bus.rd;
      d_q      <= bus.d;
      ay_ena   <= 1'b0;
      if (ck35 && en && !pause) begin
        if (div_cnt == DIV_W'(CK_DIV - 1)) begin
          div_cnt <= '0;
          ay_ena  <= 1'b1;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

  // Unpopulated select slots read back as an undriven bus.
  for (genvar i = 0; i < SLOTS; i++) begin : g_psg
    if (i < CHIPS) begin : g_chip
      ay_bank_psg u_psg (
        .CLK          (clk28),
        .ENA          (ay_ena),
        .RESET_H      (psg_rst),
        .I_DA         (d_q),
        .O_DA         (psg_do[i]),
        .busctrl_addr (addr_stb && (sel == SEL_W'(i))),
        .busctrl_we   (data_stb && (sel == SEL_W'(i))),
        .O_AUDIO_A    (ch_a[i*8 +: 8]),
        .O_AUDIO_B    (ch_b[i*8 +: 8]),
        .O_AUDIO_C    (ch_c[i*8 +: 8])
      );
    end else begin : g_empty
      assign psg_do[i] = '1;
    end
  end

  always_comb begin
    d_out_active = rd_q & bus.rd;
    d_out        = d_out_active ? psg_do[sel] : 8'hFF;
  end

  ay_mixer #(
    .CHIPS (CHIPS),
    .OUT_W (OUT_W)
  ) u_mixer (
    .clk28       (clk28),
    .rst_n       (rst_n),
    .stereo_mode (stereo_mode),
    .mute        (mute),
    .ch_a        (ch_a),
    .ch_b        (ch_b),
    .ch_c        (ch_c),
    .snd_l       (snd_l),
    .snd_r       (snd_r)
  );

endmodule

// File: tb/tb_ay_bank.sv
// Directed bench for ay_bank with an abstract register/mix model checked every cycle.
module tb_ay_bank;
  localparam int CHIPS  = 2;
  localparam int SEL_W  = 3;
  localparam int CK_DIV = 2;
  localparam int OUT_W  = 11;

  logic             clk28 = 1'b0;
  logic             rst_n = 1'b0;
  logic             ck35  = 1'b0;
  logic             en    = 1'b1;
  logic             pause = 1'b0;
  logic [1:0]       stereo_mode = 2'd0;
  logic [CHIPS-1:0] mute = '0;
  logic [7:0]       d_out;
  logic             d_out_active;
  logic [OUT_W-1:0] snd_l, snd_r;

  cpu_bus bus_if ();

  ay_bank #(
    .CHIPS  (CHIPS),
    .SEL_W  (SEL_W),
    .CK_DIV (CK_DIV),
    .OUT_W  (OUT_W)
  ) dut (
    .clk28        (clk28),
    .rst_n        (rst_n),
    .ck35         (ck35),
    .en           (en),
    .bus          (bus_if),
    .d_out        (d_out),
    .d_out_active (d_out_active),
    .pause        (pause),
    .stereo_mode  (stereo_mode),
    .mute         (mute),
    .snd_l        (snd_l),
    .snd_r        (snd_r)
  );

  always #5 clk28 = ~clk28;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Abstract model: per-chip register file, latched register index, selected chip.
  logic [7:0]  m_regs [CHIPS][16];
  logic [3:0]  m_addr [CHIPS];
  int unsigned m_sel;

  typedef struct packed {
    logic [OUT_W-1:0] l;
    logic [OUT_W-1:0] r;
    logic             ok;
  } mix_t;

  task automatic model_reset();
    for (int c = 0; c < CHIPS; c++) begin
      for (int r = 0; r < 16; r++) m_regs[c][r] = 8'h00;
      m_addr[c] = 4'h0;
    end
    m_sel = 0;
  endtask

  task automatic model_write(input logic [15:0] a, input logic [7:0] d);
    logic [2:0] i3;
    if (a[15] && a[14] && !a[1]) begin
      if (d[7:3] == 5'b11111) begin
        i3 = ~d[2:0];
        if (int'(i3) < CHIPS) m_sel = i3;
      end else if (d[7:4] == 4'h0) begin
        m_addr[m_sel] = d[3:0];
      end
    end else if (a[15] && !a[14] && !a[1]) begin
      m_regs[m_sel][m_addr[m_sel]] = d;
    end
  endtask

  // A channel is predictable when its tone is disabled (steady level) or its volume is 0.
  function automatic mix_t model_mix();
    mix_t res;
    int   lv [3];
    int   vol, al, ar;
    al = 0; ar = 0; res.ok = 1'b1;
    for (int c = 0; c < CHIPS; c++) begin
      for (int k = 0; k < 3; k++) begin
        vol = int'(m_regs[c][8+k]) & 15;
        if (m_regs[c][7][k]) lv[k] = vol * 16;
        else begin
          lv[k] = 0;
          if (vol != 0) res.ok = 1'b0;
        end
        if (mute[c]) lv[k] = 0;
      end
      case (stereo_mode)
        2'd0:    begin al += 2*lv[0] + lv[1]; ar += 2*lv[2] + lv[1]; end
        2'd1:    begin al += 2*lv[0] + lv[2]; ar += 2*lv[1] + lv[2]; end
        default: begin al += lv[0] + lv[1] + lv[2]; ar += lv[0] + lv[1] + lv[2]; end
      endcase
    end
    res.l = OUT_W'(al);
    res.r = OUT_W'(ar);
    return res;
  endfunction

  mix_t exp_q;
  always @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) exp_q <= '{l: '0, r: '0, ok: 1'b1};
    else        exp_q <= model_mix();
  end

  int quiet      = 0;
  bit watch_astb = 1'b0;
  int astb_seen  = 0;

  always @(negedge clk28) begin
    if (bus_if.wr) quiet = 0;
    else if (quiet < 8) quiet++;
    if (quiet >= 2 && exp_q.ok) begin
      check("mix_l", snd_l, exp_q.l);
      check("mix_r", snd_r, exp_q.r);
    end
    if (!bus_if.rd) begin
      check("idle_active", d_out_active, 0);
      check("idle_dout", d_out, 8'hFF);
    end
    if (watch_astb && dut.addr_stb) astb_seen++;
  end

  task automatic step();
    @(posedge clk28);
    #1;
  endtask

  task automatic bus_idle();
    bus_if.ioreq = 1'b0;
    bus_if.rd    = 1'b0;
    bus_if.wr    = 1'b0;
  endtask

  task automatic io_write(input logic [15:0] a, input logic [7:0] d);
    step();
    bus_if.a = a; bus_if.d = d; bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
    model_write(a, d);
    repeat (3) step();
    bus_idle();
    step();
  endtask

  task automatic io_reg(input logic [3:0] r, input logic [7:0] d);
    io_write(16'hFFFD, {4'h0, r});
    io_write(16'hBFFD, d);
  endtask

  task automatic io_read(input logic [15:0] a, input logic [7:0] lit);
    step();
    bus_if.a = a; bus_if.ioreq = 1'b1; bus_if.rd = 1'b1;
    @(negedge clk28);
    check("rd_first_cycle_active", d_out_active, 0);
    step();
    @(negedge clk28);
    check("rd_active", d_out_active, 1);
    check("rd_data_literal", d_out, lit);
    check("rd_data_model", d_out, m_regs[m_sel][m_addr[m_sel]]);
    step();
    bus_idle();
    step();
  endtask

  task automatic mode_change(input logic [1:0] m, input logic [CHIPS-1:0] mk,
                             input logic [OUT_W-1:0] old_l, input logic [OUT_W-1:0] old_r,
                             input logic [OUT_W-1:0] new_l, input logic [OUT_W-1:0] new_r);
    step();
    stereo_mode = m;
    mute        = mk;
    @(negedge clk28);
    check("mode_hold_l", snd_l, old_l);
    check("mode_hold_r", snd_r, old_r);
    step();
    @(negedge clk28);
    check("mode_new_l", snd_l, new_l);
    check("mode_new_r", snd_r, new_r);
  endtask

  initial begin
    bus_if.a = '0;
    bus_if.d = '0;
    bus_idle();
    model_reset();
    repeat (3) @(posedge clk28);
    #1;
    check("rst_snd_l", snd_l, 0);
    check("rst_snd_r", snd_r, 0);
    check("rst_active", d_out_active, 0);
    check("rst_sel", dut.sel, 0);
    rst_n = 1'b1;
    repeat (2) step();

    // Readback through per-chip address latches.
    io_write(16'hFFFD, 8'hFE); check("sel_chip1", dut.sel, 1);
    io_write(16'hFFFD, 8'h07);
    io_write(16'hBFFD, 8'h0F);
    io_write(16'hFFFD, 8'hFF); check("sel_chip0", dut.sel, 0);
    io_write(16'hFFFD, 8'h07);
    io_write(16'hBFFD, 8'h00);
    io_write(16'hFFFD, 8'hFE); io_read(16'hFFFD, 8'h0F);
    io_write(16'hFFFD, 8'hFF); io_read(16'hFFFD, 8'h00);

    // Out-of-range select: no change, no address strobe.
    io_write(16'hFFFD, 8'hFE);
    watch_astb = 1'b1;
    io_write(16'hFFFD, 8'hF8);
    watch_astb = 1'b0;
    check("f8_no_addr_stb", astb_seen, 0);
    check("f8_sel_held", dut.sel, 1);
    io_read(16'hFFFD, 8'h0F);
    io_write(16'hFFFD, 8'hFF);

    // AY clock enable with pause over pulses 5..8.
    for (int p = 1; p <= 10; p++) begin
      step();
      pause = (p >= 5 && p <= 8);
      ck35  = 1'b1;
      step();
      ck35  = 1'b0;
      pause = 1'b0;
      @(negedge clk28);
      check("ay_ena_pulse", dut.ay_ena, (p == 2 || p == 4 || p == 10) ? 1 : 0);
      step();
      @(negedge clk28);
      check("ay_ena_width", dut.ay_ena, 0);
    end

    // Mixer: chip0 A/B/C at steady levels 0x10/0x20/0x30, chip1 silent.
    io_reg(4'd7,  8'h3F);
    io_reg(4'd8,  8'h01);
    io_reg(4'd9,  8'h02);
    io_reg(4'd10, 8'h03);
    @(negedge clk28);
    check("abc_l", snd_l, 11'h040);
    check("abc_r", snd_r, 11'h080);
    mode_change(2'd1, 2'b00, 11'h040, 11'h080, 11'h050, 11'h070);
    mode_change(2'd2, 2'b00, 11'h050, 11'h070, 11'h060, 11'h060);
    mode_change(2'd3, 2'b00, 11'h060, 11'h060, 11'h060, 11'h060);
    mode_change(2'd2, 2'b01, 11'h060, 11'h060, 11'h000, 11'h000);
    mode_change(2'd2, 2'b10, 11'h000, 11'h000, 11'h060, 11'h060);
    mute = 2'b00;

    // Reset in the middle of a data-port write.
    io_write(16'hFFFD, 8'hFE);
    io_write(16'hFFFD, 8'h09);
    step();
    bus_if.a = 16'hBFFD; bus_if.d = 8'h55; bus_if.ioreq = 1'b1; bus_if.wr = 1'b1;
    step();
    check("pre_rst_snd_l", snd_l, 11'h060);
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_rst_sel", dut.sel, 0);
    check("mid_rst_snd_l", snd_l, 0);
    check("mid_rst_snd_r", snd_r, 0);
    check("mid_rst_active", d_out_active, 0);
    check("mid_rst_data_stb", dut.data_stb, 0);
    bus_idle();
    repeat (2) step();
    rst_n = 1'b1;
    repeat (5) begin
      @(negedge clk28);
      check("post_rst_no_data_stb", dut.data_stb, 0);
    end
    io_read(16'hFFFD, 8'h00);
    repeat (4) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
